// File: rtl/button_events_if.sv
// Button event bus: debounced button levels and tick strobe in, event pulses out.
// master: upstream / consumer side (drives tick and buttons, observes events).
// slave : the button_events block.
// The release pulse vector is named rel because release is a reserved word.
interface button_events_if #(
  parameter int unsigned NOB    = 6,
  parameter int unsigned CODE_W = 3
);
  logic              tick;      // one-cycle 1 ms strobe
  logic [NOB-1:0]    buttons;   // debounced levels, synchronous to clk
  logic [NOB-1:0]    press;     // pulse on 0->1
  logic [NOB-1:0]    rel;       // pulse on 1->0
  logic [NOB-1:0]    long;      // pulse when hold time expires
  logic [NOB-1:0]    rpt;       // auto-repeat pulse
  logic [NOB-1:0]    held;      // level, button FSM not idle
  logic              ev_valid;  // any press or rpt bit set
  logic [CODE_W-1:0] ev_code;   // lowest button index with press|rpt

  modport master (
    output tick, buttons,
    input  press, rel, long, rpt, held, ev_valid, ev_code
  );

  modport slave (
    input  tick, buttons,
    output press, rel, long, rpt, held, ev_valid, ev_code
  );
endinterface

// File: rtl/button_events.sv
// button_events: turns debounced button levels into single-cycle press, release,
// long-press and auto-repeat pulses, plus a prioritised event code for menu logic.
// Timing is counted in external tick strobes.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - button_events_if.slave: tick, buttons in; press, rel, long, rpt,
//           held, ev_valid, ev_code out (all outputs registered)
//
// Build option: define BUTTON_EVENTS_REPEAT_EN to build the auto-repeat state.
// Without it, rpt is always 0, a long press parks the FSM in HOLD until release,
// and ev_valid/ev_code reflect press only.
module button_events #(
  parameter int unsigned NOB          = 6,
  parameter int unsigned CODE_W       = 3,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic            clk,
  input  logic            reset,
  button_events_if.slave  bus
);

  if (NOB < 1 || (1 << CODE_W) < NOB || HOLD_TICKS < 1 || HOLD_TICKS >= (1 << CNT_W) ||
      REPEAT_TICKS < 1 || REPEAT_TICKS >= (1 << CNT_W)) begin : g_bad_params
    $error("button_events: parameter out of range");
  end

`ifdef BUTTON_EVENTS_REPEAT_EN
  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`endif

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_TICKS - 1);

  logic [NOB-1:0]    btn_q;
  state_e            state_q [NOB];
  state_e            state_d [NOB];
  logic [CNT_W-1:0]  cnt_q   [NOB];
  logic [CNT_W-1:0]  cnt_d   [NOB];

  logic [NOB-1:0]    press_d, rel_d, long_d, rpt_d, held_d;
  logic [NOB-1:0]    press_q, rel_q, long_q, rpt_q, held_q;
  logic [NOB-1:0]    ev_vec;
  logic              ev_valid_d, ev_valid_q;
  logic [CODE_W-1:0] ev_code_d, ev_code_q;

  always_comb begin
    for (int i = 0; i < int'(NOB); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      long_d[i]  = 1'b0;
      rpt_d[i]   = 1'b0;

      case (state_q[i])
        StIdle: begin
          // Ticks are ignored here; only a rising edge leaves IDLE.
          if (bus.buttons[i] && !btn_q[i]) begin
            state_d[i] = StHold;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end
        end
        StHold: begin
          // Release wins over a coincident tick expiry.
          if (!bus.buttons[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            rel_d[i]   = 1'b1;
          end else if (bus.tick) begin
            if (cnt_q[i] == HoldLast) begin
              long_d[i] = 1'b1;
`ifdef BUTTON_EVENTS_REPEAT_EN
              rpt_d[i]   = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = StRepeat;
`else
              // Park one past the terminal count so counting stops and long
              // cannot fire again until the button is released.
              cnt_d[i] = CNT_W'(HOLD_TICKS);
`endif
            end else if (cnt_q[i] < HoldLast) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
`ifdef BUTTON_EVENTS_REPEAT_EN
        StRepeat: begin
          if (!bus.buttons[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            rel_d[i]   = 1'b1;
          end else if (bus.tick) begin
            if (cnt_q[i] == RepeatLast) begin
              rpt_d[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase

      held_d[i] = (state_d[i] != StIdle);
    end
  end

  // Event code is derived from the next-cycle pulse vector so it lines up with
  // the registered pulses; scanning downwards leaves the lowest index winning.
  always_comb begin
    ev_vec     = press_d | rpt_d;
    ev_valid_d = |ev_vec;
    ev_code_d  = '0;
    for (int i = int'(NOB) - 1; i >= 0; i--) begin
      if (ev_vec[i]) ev_code_d = CODE_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q      <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      long_q     <= '0;
      rpt_q      <= '0;
      held_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      for (int i = 0; i < int'(NOB); i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      btn_q      <= bus.buttons;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
      held_q     <= held_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      for (int i = 0; i < int'(NOB); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.press    = press_q;
  assign bus.rel      = rel_q;
  assign bus.long     = long_q;
  assign bus.rpt      = rpt_q;
  assign bus.held     = held_q;
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_code  = ev_code_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with HOLD_TICKS=500, REPEAT_TICKS=100.
// Ticks are driven every cycle during hold sequences to keep run time short.
module tb_button_events;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  button_events_if #(.NOB(6), .CODE_W(3)) bus ();

  button_events #(
    .NOB(6), .CODE_W(3), .CNT_W(10), .HOLD_TICKS(500), .REPEAT_TICKS(100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] buttons;
    logic       tick;
    logic [5:0] press;
    logic [5:0] rel;
    logic [5:0] long;
    logic [5:0] rpt;
    logic [5:0] held;
    logic       ev_valid;
    logic [2:0] ev_code;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample 1 time unit after the active edge; inputs change right after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, bus.press, bus.rel, bus.long, bus.rpt, bus.held, bus.ev_valid, bus.ev_code};
  endfunction

  int long_n, long_at, rpt_n, evv_n, code_bad, held_bad, stray;
  int rpt_at [3];

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.buttons = '0;
    bus.tick    = 1'b0;

    //           buttons  tk press    rel      long     rpt      held     ev code
    vecs[0] = '{6'b000100, 1'b0, 6'b000100, 6'b000000, 6'b0, 6'b0, 6'b000100, 1'b1, 3'd2};
    vecs[1] = '{6'b000100, 1'b1, 6'b000000, 6'b000000, 6'b0, 6'b0, 6'b000100, 1'b0, 3'd0};
    vecs[2] = '{6'b000000, 1'b0, 6'b000000, 6'b000100, 6'b0, 6'b0, 6'b000000, 1'b0, 3'd0};
    vecs[3] = '{6'b010010, 1'b0, 6'b010010, 6'b000000, 6'b0, 6'b0, 6'b010010, 1'b1, 3'd1};
    vecs[4] = '{6'b010010, 1'b1, 6'b000000, 6'b000000, 6'b0, 6'b0, 6'b010010, 1'b0, 3'd0};
    vecs[5] = '{6'b000010, 1'b0, 6'b000000, 6'b010000, 6'b0, 6'b0, 6'b000010, 1'b0, 3'd0};
    vecs[6] = '{6'b000000, 1'b0, 6'b000000, 6'b000010, 6'b0, 6'b0, 6'b000000, 1'b0, 3'd0};
    vecs[7] = '{6'b100000, 1'b0, 6'b100000, 6'b000000, 6'b0, 6'b0, 6'b100000, 1'b1, 3'd5};
    vecs[8] = '{6'b000000, 1'b0, 6'b000000, 6'b100000, 6'b0, 6'b0, 6'b000000, 1'b0, 3'd0};
    vecs[9] = '{6'b000000, 1'b1, 6'b000000, 6'b000000, 6'b0, 6'b0, 6'b000000, 1'b0, 3'd0};

    // Reset state
    step();
    check("reset_outs_a", all_outs(), 64'd0);
    step();
    check("reset_outs_b", all_outs(), 64'd0);
    reset = 1'b0;

    // Single-cycle vectors: press, simultaneous press, glitch, idle tick
    for (int v = 0; v < 10; v++) begin
      bus.buttons = vecs[v].buttons;
      bus.tick    = vecs[v].tick;
      step();
      check($sformatf("v%0d_press", v), bus.press, vecs[v].press);
      check($sformatf("v%0d_rel", v), bus.rel, vecs[v].rel);
      check($sformatf("v%0d_long", v), bus.long, vecs[v].long);
      check($sformatf("v%0d_rpt", v), bus.rpt, vecs[v].rpt);
      check($sformatf("v%0d_held", v), bus.held, vecs[v].held);
      check($sformatf("v%0d_ev_valid", v), bus.ev_valid, vecs[v].ev_valid);
      check($sformatf("v%0d_ev_code", v), bus.ev_code, vecs[v].ev_code);
    end
    bus.tick = 1'b0;

    // Short press: 50 ticks on button 2
    bus.buttons = 6'b000100;
    step();
    check("s1_press", bus.press, 6'b000100);
    stray = 0; held_bad = 0;
    for (int t = 1; t <= 50; t++) begin
      bus.tick = 1'b1;
      step();
      if (bus.press != 0 || bus.long != 0 || bus.rpt != 0 || bus.rel != 0) stray++;
      if (bus.held != 6'b000100) held_bad++;
    end
    check("s1_stray_pulses", stray, 0);
    check("s1_held", held_bad, 0);
    bus.tick = 1'b0; bus.buttons = '0;
    step();
    check("s1_release", bus.rel, 6'b000100);
    check("s1_held_after", bus.held, 6'b0);

    // Long hold: 760 ticks on button 0
    bus.buttons = 6'b000001;
    step();
    check("s2_press", bus.press, 6'b000001);
    long_n = 0; long_at = 0; rpt_n = 0; evv_n = 0; code_bad = 0; held_bad = 0;
    rpt_at = '{0, 0, 0};
    for (int t = 1; t <= 760; t++) begin
      bus.tick = 1'b1;
      step();
      if (bus.long[0]) begin long_n++; long_at = t; end
      if (bus.rpt[0]) begin
        if (rpt_n < 3) rpt_at[rpt_n] = t;
        rpt_n++;
      end
      if (bus.ev_valid) begin
        evv_n++;
        if (bus.ev_code != 3'd0) code_bad++;
      end
      if (!bus.held[0]) held_bad++;
    end
    check("s2_long_count", long_n, 1);
    check("s2_long_tick", long_at, 500);
    check("s2_held", held_bad, 0);
    check("s2_ev_code", code_bad, 0);
`ifdef BUTTON_EVENTS_REPEAT_EN
    check("s2_rpt_count", rpt_n, 3);
    check("s2_rpt_0", rpt_at[0], 500);
    check("s2_rpt_1", rpt_at[1], 600);
    check("s2_rpt_2", rpt_at[2], 700);
    check("s2_ev_valid_count", evv_n, 3);
`else
    check("s2_rpt_count", rpt_n, 0);
    check("s2_ev_valid_count", evv_n, 0);
`endif
    bus.tick = 1'b0; bus.buttons = '0;
    step();
    check("s2_release", bus.rel, 6'b000001);
    check("s2_held_after", bus.held, 6'b0);

    // Release coincident with the 500th tick on button 3
    bus.buttons = 6'b001000;
    step();
    check("s4_press", bus.press, 6'b001000);
    stray = 0;
    for (int t = 1; t <= 499; t++) begin
      bus.tick = 1'b1;
      step();
      if (bus.long != 0 || bus.rpt != 0) stray++;
    end
    check("s4_early_long", stray, 0);
    bus.buttons = '0; bus.tick = 1'b1;
    step();
    check("s4_release", bus.rel, 6'b001000);
    check("s4_no_long", bus.long, 6'b0);
    check("s4_no_rpt", bus.rpt, 6'b0);
    check("s4_held", bus.held, 6'b0);
    step();
    check("s4_idle_after", all_outs(), 64'd0);
    bus.tick = 1'b0;

    // Reset mid-operation with button 5 held, past the long press
    bus.buttons = 6'b100000;
    step();
    check("s5_press", bus.press, 6'b100000);
    for (int t = 1; t <= 520; t++) begin
      bus.tick = 1'b1;
      step();
    end
    bus.tick = 1'b0;
    check("s5_held_before_reset", bus.held, 6'b100000);
    #3;
    reset = 1'b1;
    #1;
    check("s5_async_clear", all_outs(), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("s5_in_reset_%0d", c), all_outs(), 64'd0);
    end
    reset = 1'b0;
    step();
    check("s5_press_after_reset", bus.press, 6'b100000);
    check("s5_ev_valid", bus.ev_valid, 1'b1);
    check("s5_ev_code", bus.ev_code, 3'd5);
    long_n = 0; long_at = 0;
    for (int t = 1; t <= 500; t++) begin
      bus.tick = 1'b1;
      step();
      if (bus.long[5]) begin long_n++; long_at = t; end
    end
    check("s5_long_count", long_n, 1);
    check("s5_long_tick", long_at, 500);
    bus.tick = 1'b0; bus.buttons = '0;
    step();
    check("s5_release", bus.rel, 6'b100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
